// File: rtl/cnu_serial_if.sv
// Handshake bundle between the VNU array / message RAM side and the
// serial min-sum check node unit. The testbench drives the master side.
interface cnu_serial_if #(
    parameter int data_w = 8,
    parameter int idx_w  = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [data_w-1:0] q_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [data_w-1:0] r_out;
    logic [idx_w-1:0]         r_idx;
    logic                     parity_ok;
    logic                     frame_done;

    modport master (
        output in_valid, q_in, out_ready,
        input  in_ready, out_valid, r_out, r_idx, parity_ok, frame_done
    );

    modport slave (
        input  in_valid, q_in, out_ready,
        output in_ready, out_valid, r_out, r_idx, parity_ok, frame_done
    );
endinterface

// File: rtl/cnu_serial.sv
// Serial min-sum check node unit. Collects DC variable-to-check messages
// one per cycle, tracking the two smallest magnitudes, the index of the
// smallest and the running sign product, then emits DC extrinsic
// check-to-variable messages, each built without its own input.
module cnu_serial #(
    parameter int data_w = 8,
    parameter int DC     = 6,
    parameter int idx_w  = 3,
    parameter int OFFSET = 0
) (
    input  logic            clk,
    input  logic            rst,
    cnu_serial_if.slave     bus
);

    localparam logic [idx_w-1:0]  LAST     = idx_w'(DC - 1);
    localparam logic [data_w-1:0] MAXV     = {1'b0, {(data_w-1){1'b1}}};
    localparam logic [data_w-1:0] MOST_NEG = {1'b1, {(data_w-1){1'b0}}};
    localparam logic [data_w-1:0] OFF      = data_w'(OFFSET);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t            state;
    logic [idx_w-1:0]  cnt;
    logic [data_w-1:0] min1;
    logic [data_w-1:0] min2;
    logic [idx_w-1:0]  min_idx;
    logic              sign_acc;
    logic [DC-1:0]     sgn;

    logic [data_w-1:0] mag;
    logic              s_in;
    logic              accept;
    logic              emit_fire;

    // Saturated magnitude and sign of the incoming message; the most negative
    // code has no positive twin, so it is clipped to the largest magnitude.
    always_comb begin
        s_in = bus.q_in[data_w-1];
        mag  = bus.q_in;
        if (s_in) begin
            mag = (bus.q_in == MOST_NEG) ? MAXV : -bus.q_in;
        end
        accept    = bus.in_valid && (state == COLLECT);
        emit_fire = bus.out_ready && (state == EMIT);
    end

    // Frame state machine: gathers min1/min2/sign statistics, then steps
    // through the outgoing edges as downstream accepts them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            cnt        <= '0;
            min1       <= MAXV;
            min2       <= MAXV;
            min_idx    <= '0;
            sign_acc   <= 1'b0;
            sgn        <= '0;
            bus.parity_ok  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (accept) begin
                sgn[cnt] <= s_in;
                sign_acc <= sign_acc ^ s_in;
                if (mag < min1) begin
                    min2    <= min1;
                    min1    <= mag;
                    min_idx <= cnt;
                end else if (mag < min2) begin
                    min2 <= mag;
                end
                if (cnt == LAST) begin
                    state         <= EMIT;
                    cnt           <= '0;
                    bus.parity_ok <= ~(sign_acc ^ s_in);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (emit_fire) begin
                if (cnt == LAST) begin
                    state          <= COLLECT;
                    cnt            <= '0;
                    min1           <= MAXV;
                    min2           <= MAXV;
                    min_idx        <= '0;
                    sign_acc       <= 1'b0;
                    bus.frame_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    logic [data_w-1:0] m_sel;
    logic [data_w-1:0] m_off;
    logic              neg;

    // Extrinsic output for edge cnt: the minimum over all other edges,
    // offset-reduced, carrying the sign product with this edge's sign removed.
    always_comb begin
        bus.in_ready  = (state == COLLECT);
        bus.out_valid = (state == EMIT);
        m_sel         = (cnt == min_idx) ? min2 : min1;
        m_off         = (m_sel > OFF) ? (m_sel - OFF) : '0;
        neg           = sign_acc ^ sgn[cnt];
        bus.r_out     = '0;
        bus.r_idx     = '0;
        if (state == EMIT) begin
            bus.r_out = neg ? -m_off : m_off;
            bus.r_idx = cnt;
        end
    end

endmodule

// File: tb/tb_cnu_serial.sv
// Directed bench for cnu_serial. Two instances (offset 0 and offset 1) see
// the same stimulus; expected messages go into a scoreboard queue when a
// frame is driven and are popped as each output is accepted.
module tb_cnu_serial;

    logic clk;
    logic rst;
    logic in_valid;
    logic signed [7:0] q_in;
    logic out_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic signed [7:0] r0;
        logic signed [7:0] r1;
        logic [2:0]        idx;
    } exp_t;

    exp_t sb[$];

    cnu_serial_if #(.data_w(8), .idx_w(3)) bus0 ();
    cnu_serial_if #(.data_w(8), .idx_w(3)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.q_in      = q_in;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.q_in      = q_in;
    assign bus1.out_ready = out_ready;

    cnu_serial #(.data_w(8), .DC(6), .idx_w(3), .OFFSET(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    cnu_serial #(.data_w(8), .DC(6), .idx_w(3), .OFFSET(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sendOne(input logic signed [7:0] q);
        int n;
        in_valid = 1'b1;
        q_in     = q;
        n = 0;
        while (!bus0.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", bus0.in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic signed [7:0] q [6],
                                 input logic signed [7:0] e0 [6],
                                 input logic signed [7:0] e1 [6]);
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            e.r0  = e0[k];
            e.r1  = e1[k];
            e.idx = 3'(k);
            sb.push_back(e);
        end
        for (int k = 0; k < 6; k++) sendOne(q[k]);
    endtask

    task automatic checkOutput(input bit stall, input bit junk, input logic exp_par);
        exp_t e;
        int   cycles;
        bit   stalled;
        cycles  = 0;
        stalled = 0;
        out_ready = 1'b1;
        if (junk) begin
            in_valid = 1'b1;
            q_in     = -8'sd50;
        end
        while (sb.size() > 0 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            chk("frame_done_early", bus0.frame_done, 0);
            if (stall && !stalled && bus0.out_valid && bus0.r_idx == 3'd2) begin
                out_ready = 1'b0;
                stalled   = 1;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_r_out", $signed(bus0.r_out), 2);
                    chk("stall_r_idx", bus0.r_idx, 2);
                    chk("stall_in_ready", bus0.in_ready, 0);
                    chk("stall_frame_done", bus0.frame_done, 0);
                end
                out_ready = 1'b1;
            end
            if (bus0.out_valid && out_ready) begin
                e = sb.pop_front();
                chk("r_out_off0", $signed(bus0.r_out), $signed(e.r0));
                chk("r_out_off1", $signed(bus1.r_out), $signed(e.r1));
                chk("r_idx", bus0.r_idx, e.idx);
                if (sb.size() == 0) in_valid = 1'b0;
            end
        end
        chk("emit_drained", sb.size(), 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("frame_done_pulse", bus0.frame_done, 1);
        chk("in_ready_after", bus0.in_ready, 1);
        chk("parity_ok", bus0.parity_ok, exp_par);
        @(negedge clk);
        chk("frame_done_clear", bus0.frame_done, 0);
        chk("parity_hold", bus0.parity_ok, exp_par);
    endtask

    // Linear directed sequence
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        q_in      = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus0.in_ready, 1);
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_r_out", $signed(bus0.r_out), 0);
        chk("rst_r_idx", bus0.r_idx, 0);
        chk("rst_parity", bus0.parity_ok, 0);
        chk("rst_frame_done", bus0.frame_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame, with junk in_valid during emission
        applyStimulus('{5, -3, 7, 2, -9, 4}, '{2, -2, 2, 3, -2, 2}, '{1, -1, 1, 2, -1, 1});
        checkOutput(0, 1, 1'b1);

        // Odd sign count, smallest at edge 0
        applyStimulus('{-1, 2, 3, 4, 5, 6}, '{2, -1, -1, -1, -1, -1}, '{1, 0, 0, 0, 0, 0});
        checkOutput(0, 0, 1'b0);

        // Saturation of the most negative code
        applyStimulus('{-128, 127, 100, 100, 120, -1}, '{-1, 1, 1, 1, 1, -100},
                      '{0, 0, 0, 0, 0, -99});
        checkOutput(0, 0, 1'b1);

        // All-equal magnitudes
        applyStimulus('{4, 4, 4, 4, 4, 4}, '{4, 4, 4, 4, 4, 4}, '{3, 3, 3, 3, 3, 3});
        checkOutput(0, 0, 1'b1);

        // Offset clamps to zero
        applyStimulus('{1, 1, 1, 1, 1, 1}, '{1, 1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0, 0});
        checkOutput(0, 0, 1'b1);

        // Back-pressure at edge 2
        applyStimulus('{5, -3, 7, 2, -9, 4}, '{2, -2, 2, 3, -2, 2}, '{1, -1, 1, 2, -1, 1});
        checkOutput(1, 0, 1'b1);

        // Reset mid-frame discards the partial inputs
        sendOne(-8'sd1);
        sendOne(8'sd2);
        sendOne(-8'sd3);
        rst = 1'b1;
        #2;
        chk("midrst_in_ready", bus0.in_ready, 1);
        chk("midrst_parity", bus0.parity_ok, 0);
        chk("midrst_out_valid", bus0.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus('{5, -3, 7, 2, -9, 4}, '{2, -2, 2, 3, -2, 2}, '{1, -1, 1, 2, -1, 1});
        checkOutput(0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
